// File: rtl/adder_feeder.sv
// Serial-to-parallel operand gatherer for the registered adder: collects Num words per group,
// zero-pads early-terminated groups and presents each group with a one-cycle valid strobe.
module adder_feeder #(
  parameter int unsigned Bits = 32,
  parameter int unsigned Num  = 2,
  parameter int unsigned Cw   = $clog2(Num + 1)
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     in_valid_i,
  input  logic [Bits-1:0]          in_data_i,
  input  logic                     in_last_i,
  output logic                     in_ready_o,
  input  logic                     hold_i,
  output logic                     valid_o,
  output logic [Num-1:0][Bits-1:0] data_o,
  output logic [Cw-1:0]            cnt_o
);

  localparam int unsigned IdxW = (Num > 1) ? $clog2(Num) : 1;

  logic [Num-1:0][Bits-1:0] r_q, r_d;
  logic [IdxW-1:0]          idx_q, idx_d;
  logic [Cw-1:0]            cnt_q, cnt_d;
  logic                     full_q, full_d;

  logic accept;
  logic last_slot;
  logic complete;

  assign in_ready_o = !full_q || !hold_i;
  assign accept     = in_valid_i && in_ready_o;
  assign last_slot  = (idx_q == IdxW'(Num - 1));
  assign complete   = accept && (last_slot || in_last_i);

  assign valid_o = full_q && !hold_i;
  assign data_o  = r_q;
  assign cnt_o   = cnt_q;

  always_comb begin
    r_d    = r_q;
    idx_d  = idx_q;
    cnt_d  = cnt_q;
    full_d = (full_q && hold_i) || complete;
    if (accept) begin
      r_d[idx_q] = in_data_i;
      if (complete) begin
        // Slots past the terminating word are zero-padded for a short group.
        for (int k = 0; k < int'(Num); k++) begin
          if (k > int'(idx_q)) r_d[k] = '0;
        end
        cnt_d = Cw'(idx_q) + Cw'(1);
        idx_d = '0;
      end else begin
        idx_d = IdxW'(idx_q + 1'b1);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_q    <= '0;
      idx_q  <= '0;
      cnt_q  <= '0;
      full_q <= 1'b0;
    end else begin
      r_q    <= r_d;
      idx_q  <= idx_d;
      cnt_q  <= cnt_d;
      full_q <= full_d;
    end
  end

endmodule

// File: tb/tb_adder_feeder.sv
// Directed bench for adder_feeder: a Num=2 vector table plus hand-written hold, streaming,
// Num=1 back-to-back and Num=4 mid-group reset sequences.
module tb_adder_feeder;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Num=2 instance
  logic              a_iv, a_last, a_hold, a_ready, a_valid;
  logic [31:0]       a_d;
  logic [1:0][31:0]  a_o;
  logic [1:0]        a_cnt;
  adder_feeder #(.Bits(32), .Num(2)) u_n2 (
    .clk_i(clk), .rst_i(rst), .in_valid_i(a_iv), .in_data_i(a_d), .in_last_i(a_last),
    .in_ready_o(a_ready), .hold_i(a_hold), .valid_o(a_valid), .data_o(a_o), .cnt_o(a_cnt)
  );

  // Num=4 instance
  logic              b_iv, b_last, b_hold, b_ready, b_valid;
  logic [31:0]       b_d;
  logic [3:0][31:0]  b_o;
  logic [2:0]        b_cnt;
  adder_feeder #(.Bits(32), .Num(4)) u_n4 (
    .clk_i(clk), .rst_i(rst), .in_valid_i(b_iv), .in_data_i(b_d), .in_last_i(b_last),
    .in_ready_o(b_ready), .hold_i(b_hold), .valid_o(b_valid), .data_o(b_o), .cnt_o(b_cnt)
  );

  // Num=1 instance
  logic              c_iv, c_last, c_hold, c_ready, c_valid;
  logic [31:0]       c_d;
  logic [0:0][31:0]  c_o;
  logic [0:0]        c_cnt;
  adder_feeder #(.Bits(32), .Num(1)) u_n1 (
    .clk_i(clk), .rst_i(rst), .in_valid_i(c_iv), .in_data_i(c_d), .in_last_i(c_last),
    .in_ready_o(c_ready), .hold_i(c_hold), .valid_o(c_valid), .data_o(c_o), .cnt_o(c_cnt)
  );

  typedef struct {
    logic        iv;
    logic [31:0] d;
    logic        last;
    logic        hold;
    logic        ready;
    logic        valid;
    logic        chk;
    logic [31:0] o0;
    logic [31:0] o1;
    logic [1:0]  cnt;
  } vec_t;

  vec_t vecs[16];

  initial begin
    int p;
    logic seen_stale;
    logic [31:0] c_vals[3];

    // iv, d, last, hold | ready, valid, chk, o0, o1, cnt  (outputs seen before the edge)
    vecs[0]  = '{1'b1, 32'h5,  1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0,  32'h0,  2'd0};
    vecs[1]  = '{1'b1, 32'h7,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,  32'h0,  2'd0};
    vecs[2]  = '{1'b0, 32'h0,  1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h5,  32'h7,  2'd2};
    vecs[3]  = '{1'b1, 32'h10, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,  32'h0,  2'd0};
    vecs[4]  = '{1'b1, 32'h20, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h10, 32'h0,  2'd1};
    vecs[5]  = '{1'b1, 32'h21, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,  32'h0,  2'd0};
    vecs[6]  = '{1'b0, 32'h0,  1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h20, 32'h21, 2'd2};
    vecs[7]  = '{1'b1, 32'h99, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h20, 32'h21, 2'd2};
    vecs[8]  = '{1'b0, 32'h0,  1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h20, 32'h21, 2'd2};
    vecs[9]  = '{1'b0, 32'h0,  1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,  32'h0,  2'd0};
    vecs[10] = '{1'b1, 32'h3,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,  32'h0,  2'd0};
    vecs[11] = '{1'b1, 32'h4,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,  32'h0,  2'd0};
    vecs[12] = '{1'b0, 32'h0,  1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h3,  32'h4,  2'd2};
    vecs[13] = '{1'b1, 32'h8,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,  32'h0,  2'd0};
    vecs[14] = '{1'b1, 32'h9,  1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,  32'h0,  2'd0};
    vecs[15] = '{1'b0, 32'h0,  1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h8,  32'h9,  2'd2};

    rst = 1'b1;
    {a_iv, a_last, a_hold, b_iv, b_last, b_hold, c_iv, c_last, c_hold} = '0;
    a_d = '0; b_d = '0; c_d = '0;
    @(negedge clk);
    #1;
    check("rst_a_valid", a_valid, 0);
    check("rst_a_ready", a_ready, 1);
    check("rst_a_o", a_o, 0);
    check("rst_a_cnt", a_cnt, 0);
    check("rst_b_o", b_o, 0);
    check("rst_c_valid", c_valid, 0);
    @(negedge clk);
    rst = 1'b0;

    // Num=2 vector table
    for (int i = 0; i < 16; i++) begin
      if (i != 0) @(negedge clk);
      a_iv = vecs[i].iv; a_d = vecs[i].d; a_last = vecs[i].last; a_hold = vecs[i].hold;
      #1;
      check($sformatf("vec%0d_ready", i), a_ready, vecs[i].ready);
      check($sformatf("vec%0d_valid", i), a_valid, vecs[i].valid);
      if (vecs[i].chk) begin
        check($sformatf("vec%0d_o0", i), a_o[0], vecs[i].o0);
        check($sformatf("vec%0d_o1", i), a_o[1], vecs[i].o1);
        check($sformatf("vec%0d_cnt", i), a_cnt, vecs[i].cnt);
      end
    end

    // Hold: feed 1,2 under hold, group stays frozen, then release while accepting 3
    @(negedge clk); a_hold = 1; a_iv = 1; a_d = 1; a_last = 0; #1;
    check("hold_w1_ready", a_ready, 1);
    @(negedge clk); a_d = 2; #1;
    check("hold_w2_ready", a_ready, 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); a_d = 3; #1;
      check($sformatf("hold%0d_ready", i), a_ready, 0);
      check($sformatf("hold%0d_valid", i), a_valid, 0);
      check($sformatf("hold%0d_o", i), a_o, {32'd2, 32'd1});
      check($sformatf("hold%0d_cnt", i), a_cnt, 2);
    end
    @(negedge clk); a_hold = 0; #1;
    check("rel_valid", a_valid, 1);
    check("rel_ready", a_ready, 1);
    check("rel_o", a_o, {32'd2, 32'd1});
    @(negedge clk); a_d = 4; #1;
    check("rel_next_valid", a_valid, 0);
    @(negedge clk); a_iv = 0; #1;
    check("grp34_valid", a_valid, 1);
    check("grp34_o", a_o, {32'd4, 32'd3});

    // Continuous stream 1..8: pulses expected in cycles 2,4,6,8 of the window
    p = 0;
    for (int j = 0; j < 12; j++) begin
      @(negedge clk);
      a_iv = (j < 8); a_d = 32'(j + 1);
      #1;
      if (j < 8) check($sformatf("stream%0d_ready", j), a_ready, 1);
      if (a_valid) begin
        check($sformatf("pulse%0d_cycle", p), j, 2 * p + 2);
        check($sformatf("pulse%0d_o", p), a_o, {32'(2 * p + 2), 32'(2 * p + 1)});
        p++;
      end
    end
    check("stream_pulses", p, 4);

    // Num=1: every accepted word is its own group
    c_vals[0] = 32'hFFFF_FFFF; c_vals[1] = 32'h0; c_vals[2] = 32'h8000_0000;
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      c_iv = (j < 3); c_d = (j < 3) ? c_vals[j] : 32'h0;
      #1;
      check($sformatf("n1_c%0d_valid", j), c_valid, (j >= 1 && j <= 3));
      if (j >= 1 && j <= 3) begin
        check($sformatf("n1_c%0d_o", j), c_o[0], c_vals[j-1]);
        check($sformatf("n1_c%0d_cnt", j), c_cnt, 1);
      end
    end
    c_iv = 0;

    // Num=4: partial group discarded by reset
    @(negedge clk); b_iv = 1; b_d = 32'hA;
    @(negedge clk); b_d = 32'hB;
    @(negedge clk); b_iv = 0; rst = 1; #1;
    check("n4_rst_valid", b_valid, 0);
    check("n4_rst_ready", b_ready, 1);
    @(negedge clk); rst = 0; #1;
    check("n4_post_rst_valid", b_valid, 0);
    check("n4_post_rst_o", b_o, 0);
    p = 0;
    seen_stale = 0;
    for (int j = 0; j < 8; j++) begin
      if (j != 0) @(negedge clk);
      b_iv = (j < 4); b_d = 32'(j + 1);
      #1;
      for (int k = 0; k < 4; k++) begin
        if (b_o[k] == 32'hA || b_o[k] == 32'hB) seen_stale = 1;
      end
      if (b_valid) begin
        check("n4_cycle", j, 4);
        check("n4_o", b_o, {32'd4, 32'd3, 32'd2, 32'd1});
        check("n4_cnt", b_cnt, 4);
        p++;
      end
    end
    check("n4_pulses", p, 1);
    check("n4_no_stale", seen_stale, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
